note_tone_gen: RTL

Inverse of the frequency-to-note path: accepts an 8-bit note code and a duration over a valid/ready handshake, then produces a square-wave tone at that note's pitch for that long, followed by a fixed silent articulation gap. The note code uses the encoding shared with the pitch detector: [7:5] note letter, [4:3] accidental, [2:0] octave. The block sits between the melody sequencer and the audio PWM/speaker output. Pitch comes from compile-time half-period constants shifted by octave, so there is no runtime divider.

---
 rtl/note_tone_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/note_tone_gen.sv
// Note-code to square-wave tone generator with a fixed silent gap after every note.
// Optional registered signed sample output is enabled by defining NOTE_TONE_SAMPLE_EN.
module note_tone_gen #(
    parameter int                 CLK_HZ = 100_000_000,
    parameter int                 DUR_W  = 12,
    parameter int                 GAP_MS = 10,
    parameter int                 HP_W   = 24,
    parameter logic signed [15:0] AMP    = 16'sd8192
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [7:0]       note_code_in,
    input  logic [DUR_W-1:0] dur_ms_in,
    input  logic             note_valid_in,
    output logic             note_ready_out,
    output logic             tone_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out,
    output logic [7:0]       cur_note_out
`ifdef NOTE_TONE_SAMPLE_EN
    ,
    output logic signed [15:0] sample_out
`endif
);

    localparam int MS_CYCLES = CLK_HZ / 1000;
    localparam int SUB_W     = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int GAP_W     = $clog2(GAP_MS + 1);
    localparam int MS_W      = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Half periods of octave 0, one per semitone starting at A.
    function automatic logic [HP_W-1:0] hp_base(input logic [3:0] idx);
        case (idx)
            4'd0:    hp_base = HP_W'(CLK_HZ / (2 * 440));
            4'd1:    hp_base = HP_W'(CLK_HZ / (2 * 466));
            4'd2:    hp_base = HP_W'(CLK_HZ / (2 * 494));
            4'd3:    hp_base = HP_W'(CLK_HZ / (2 * 523));
            4'd4:    hp_base = HP_W'(CLK_HZ / (2 * 554));
            4'd5:    hp_base = HP_W'(CLK_HZ / (2 * 587));
            4'd6:    hp_base = HP_W'(CLK_HZ / (2 * 622));
            4'd7:    hp_base = HP_W'(CLK_HZ / (2 * 659));
            4'd8:    hp_base = HP_W'(CLK_HZ / (2 * 698));
            4'd9:    hp_base = HP_W'(CLK_HZ / (2 * 740));
            4'd10:   hp_base = HP_W'(CLK_HZ / (2 * 784));
            4'd11:   hp_base = HP_W'(CLK_HZ / (2 * 831));
            default: hp_base = '0;
        endcase
    endfunction

    state_t            state, state_d;
    logic [SUB_W-1:0]  sub_cnt;
    logic [MS_W-1:0]   ms_left;
    logic [HP_W-1:0]   phase, hp;
    logic              tone, tone_d;
    logic              rest, rest_d;

    logic [2:0]        letter, octave;
    logic [1:0]        accidental;
    logic [3:0]        nat_idx, semi_idx;
    logic [HP_W-1:0]   hp_new;
    logic              is_rest, bad, accept, sub_end, wrap, last_ms;

    // Decode of the incoming request; only meaningful in the accepting cycle.
    always_comb begin
        letter     = note_code_in[7:5];
        accidental = note_code_in[4:3];
        octave     = note_code_in[2:0];
        is_rest    = (letter == 3'd7) || (octave == 3'd7);
        case (letter)
            3'd0:    nat_idx = 4'd0;
            3'd1:    nat_idx = 4'd2;
            3'd2:    nat_idx = 4'd3;
            3'd3:    nat_idx = 4'd5;
            3'd4:    nat_idx = 4'd7;
            3'd5:    nat_idx = 4'd8;
            3'd6:    nat_idx = 4'd10;
            default: nat_idx = 4'd0;
        endcase
        semi_idx = nat_idx + {3'b000, accidental[0]};
        hp_new   = hp_base(semi_idx) >> octave;
        bad      = accidental[1]
                 || (accidental[0] && ((letter == 3'd1) || (letter == 3'd4)))
                 || (!is_rest && (hp_new < HP_W'(2)));
    end

    assign accept  = note_valid_in && (state == IDLE);
    assign sub_end = (sub_cnt == SUB_W'(MS_CYCLES - 1));
    assign last_ms = (ms_left == MS_W'(1));
    assign wrap    = (phase == hp - HP_W'(1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        tone_d  = tone;
        rest_d  = rest;
        case (state)
            IDLE: begin
                if (accept && !bad) begin
                    state_d = (dur_ms_in == '0) ? GAP : PLAY;
                    rest_d  = is_rest;
                end
            end
            PLAY:    if (sub_end && last_ms) state_d = GAP;
            GAP:     if (sub_end && last_ms) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != PLAY)
            tone_d = 1'b0;
        else if ((state == PLAY) && wrap && !rest)
            tone_d = ~tone;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_cnt      <= '0;
            ms_left      <= '0;
            phase        <= '0;
            hp           <= '0;
            tone         <= 1'b0;
            rest         <= 1'b0;
            cur_note_out <= '0;
            done_out     <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            tone     <= tone_d;
            rest     <= rest_d;
            done_out <= (state == GAP) && (state_d == IDLE);
            err_out  <= accept && bad;
            case (state)
                IDLE: begin
                    sub_cnt <= '0;
                    phase   <= '0;
                    if (accept && !bad) begin
                        cur_note_out <= note_code_in;
                        hp           <= hp_new;
                        ms_left      <= (dur_ms_in == '0) ? MS_W'(GAP_MS) : MS_W'(dur_ms_in);
                    end
                end
                PLAY, GAP: begin
                    sub_cnt <= sub_end ? '0 : sub_cnt + SUB_W'(1);
                    phase   <= (wrap || state == GAP) ? '0 : phase + HP_W'(1);
                    if (sub_end)
                        ms_left <= (state == PLAY && last_ms) ? MS_W'(GAP_MS) : ms_left - MS_W'(1);
                    if (state_d == IDLE)
                        cur_note_out <= '0;
                end
                default: ;
            endcase
        end
    end

    assign note_ready_out = (state == IDLE);
    assign busy_out       = (state != IDLE);
    assign tone_out       = tone;

`ifdef NOTE_TONE_SAMPLE_EN
    // Built from next-state values so the sample lines up with tone_out.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            sample_out <= '0;
        else if ((state_d == PLAY) && !rest_d)
            sample_out <= tone_d ? AMP : -AMP;
        else
            sample_out <= '0;
    end
`endif

endmodule
